// File: rtl/udma_rx_dp_pkg.sv
// Shared types and helpers for the uDMA RX data-path packer: beat sizes, FSM states,
// the queued L2 write-request entry, and byte-enable / lane-mask helpers.
package udma_rx_dp_pkg;

  localparam int L2_ADDR_W = 32;

  typedef enum logic [1:0] {
    DS_BYTE = 2'd0,
    DS_HALF = 2'd1,
    DS_WORD = 2'd2
  } dsize_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [L2_ADDR_W-1:0] addr;
    logic [31:0]          wdata;
    logic [3:0]           be;
  } req_entry_t;

  // ((1 << nbytes) - 1) << lane, limited to the four byte lanes of a word
  function automatic logic [3:0] calc_be(input logic [2:0] nbytes, input logic [1:0] lane);
    logic [7:0] m;
    m = (8'd1 << nbytes) - 8'd1;
    m = m << lane;
    return m[3:0];
  endfunction

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/udma_rx_dp_req_fifo.sv
// Small synchronous FIFO of L2 write-request entries with full/empty flags,
// an occupancy count, and concurrent push/pop (also when full).
module udma_rx_dp_req_fifo
  import udma_rx_dp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  req_entry_t               push_data_i,
  input  logic                     pop_i,
  output req_entry_t               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  req_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/udma_rx_dp_packer.sv
// RX packer: converts peripheral RX beats into byte-enabled 32-bit L2 write requests.
// Define UDMA_RX_DP_CONT_EN to add cfg_continuous_i (auto-reload of address/size).
module udma_rx_dp_packer
  import udma_rx_dp_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int TRANS_W    = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               cfg_start_i,
  input  logic [ADDR_W-1:0]  cfg_addr_i,
  input  logic [TRANS_W-1:0] cfg_size_i,
  input  logic               cfg_stop_i,
`ifdef UDMA_RX_DP_CONT_EN
  input  logic               cfg_continuous_i,
`endif
  input  logic               rx_valid_i,
  output logic               rx_ready_o,
  input  logic [31:0]        rx_data_i,
  input  logic [1:0]         rx_datasize_i,
  output logic               dp_req_o,
  input  logic               dp_gnt_i,
  output logic               dp_we_o,
  output logic [ADDR_W-1:0]  dp_addr_o,
  output logic [31:0]        dp_wdata_o,
  output logic [3:0]         dp_be_o,
  output logic               busy_o,
  output logic [TRANS_W-1:0] bytes_left_o,
  output logic               done_o,
  output logic               err_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [TRANS_W-1:0] r_bytes_left;
  logic               r_done;
  logic               r_err;
`ifdef UDMA_RX_DP_CONT_EN
  logic [ADDR_W-1:0]  r_shadow_addr;
  logic [TRANS_W-1:0] r_shadow_size;
`endif

  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic               w_accept;
  logic               w_misaligned;
  logic               w_push;
  logic               w_pop;
  logic               w_empty_next;
  logic [2:0]         w_nbytes;
  logic [2:0]         w_eff;
  logic [1:0]         w_lane;
  logic [3:0]         w_be;
  logic [TRANS_W-1:0] w_left_after;
  req_entry_t         w_push_entry;
  req_entry_t         w_head;

  assign rx_ready_o = (r_state == ST_RUN) && !w_full;
  assign w_accept   = rx_valid_i && rx_ready_o;
  assign w_lane     = r_addr[1:0];

  // Reserved size code 3 falls into the word branch.
  always_comb begin
    w_nbytes     = 3'd4;
    w_misaligned = |r_addr[1:0];
    case (rx_datasize_i)
      DS_BYTE: begin
        w_nbytes     = 3'd1;
        w_misaligned = 1'b0;
      end
      DS_HALF: begin
        w_nbytes     = 3'd2;
        w_misaligned = r_addr[0];
      end
      default: ;
    endcase
  end

  assign w_eff        = (TRANS_W'(w_nbytes) > r_bytes_left) ? r_bytes_left[2:0] : w_nbytes;
  assign w_be         = calc_be(w_eff, w_lane);
  assign w_left_after = r_bytes_left - TRANS_W'(w_eff);
  assign w_push       = w_accept && !w_misaligned;

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.addr  = L2_ADDR_W'({r_addr[ADDR_W-1:2], 2'b00});
    w_push_entry.wdata = (rx_data_i << {w_lane, 3'b000}) & be_to_mask(w_be);
    w_push_entry.be    = w_be;
  end

  udma_rx_dp_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (w_push),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  assign dp_req_o   = !w_empty;
  assign dp_we_o    = dp_req_o;
  assign w_pop      = dp_req_o && dp_gnt_i;
  assign dp_addr_o  = w_empty ? '0 : w_head.addr[ADDR_W-1:0];
  assign dp_wdata_o = w_empty ? '0 : w_head.wdata;
  assign dp_be_o    = w_empty ? '0 : w_head.be;

  assign busy_o       = (r_state != ST_IDLE) || !w_empty;
  assign bytes_left_o = r_bytes_left;
  assign done_o       = r_done;
  assign err_o        = r_err;

  // True when the FIFO will hold nothing after this cycle's push/pop.
  assign w_empty_next = ((w_count == CNT_W'(0)) && !w_push) ||
                        ((w_count == CNT_W'(1)) && w_pop && !w_push);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_bytes_left <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef UDMA_RX_DP_CONT_EN
      r_shadow_addr <= '0;
      r_shadow_size <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= w_accept && w_misaligned;
      if (cfg_stop_i) begin
        r_bytes_left <= '0;
        if (w_empty_next) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end else begin
          r_state <= ST_DRAIN;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (cfg_start_i && (cfg_size_i != '0)) begin
              r_addr       <= cfg_addr_i;
              r_bytes_left <= cfg_size_i;
              r_state      <= ST_RUN;
`ifdef UDMA_RX_DP_CONT_EN
              r_shadow_addr <= cfg_addr_i;
              r_shadow_size <= cfg_size_i;
`endif
            end
          end
          ST_RUN: begin
            if (w_push) begin
              r_addr       <= r_addr + ADDR_W'(w_eff);
              r_bytes_left <= w_left_after;
              if (w_left_after == '0) begin
`ifdef UDMA_RX_DP_CONT_EN
                if (cfg_continuous_i) begin
                  r_addr       <= r_shadow_addr;
                  r_bytes_left <= r_shadow_size;
                  r_done       <= 1'b1;
                end else begin
                  r_state <= ST_DRAIN;
                end
`else
                r_state <= ST_DRAIN;
`endif
              end
            end
          end
          ST_DRAIN: begin
            if (w_empty_next) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udma_rx_dp_packer.sv
// Scoreboard bench for udma_rx_dp_packer: directed scenarios plus randomized transfers
// checked against a byte-level reference model of the packing rules.
module tb_udma_rx_dp_packer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_i;
  logic        cfg_start_i;
  logic [31:0] cfg_addr_i;
  logic [19:0] cfg_size_i;
  logic        cfg_stop_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [31:0] rx_data_i;
  logic [1:0]  rx_datasize_i;
  logic        dp_req_o;
  logic        dp_gnt_i;
  logic        dp_we_o;
  logic [31:0] dp_addr_o;
  logic [31:0] dp_wdata_o;
  logic [3:0]  dp_be_o;
  logic        busy_o;
  logic [19:0] bytes_left_o;
  logic        done_o;
  logic        err_o;

  udma_rx_dp_packer #(
    .ADDR_W     (32),
    .TRANS_W    (20),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .cfg_start_i      (cfg_start_i),
    .cfg_addr_i       (cfg_addr_i),
    .cfg_size_i       (cfg_size_i),
    .cfg_stop_i       (cfg_stop_i),
`ifdef UDMA_RX_DP_CONT_EN
    .cfg_continuous_i (1'b0),
`endif
    .rx_valid_i       (rx_valid_i),
    .rx_ready_o       (rx_ready_o),
    .rx_data_i        (rx_data_i),
    .rx_datasize_i    (rx_datasize_i),
    .dp_req_o         (dp_req_o),
    .dp_gnt_i         (dp_gnt_i),
    .dp_we_o          (dp_we_o),
    .dp_addr_o        (dp_addr_o),
    .dp_wdata_o       (dp_wdata_o),
    .dp_be_o          (dp_be_o),
    .busy_o           (busy_o),
    .bytes_left_o     (bytes_left_o),
    .done_o           (done_o),
    .err_o            (err_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  logic [31:0] m_addr;
  int          m_left;
  int          gnt_mode = 0;

  logic        prev_pend;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;
  logic [3:0]  prev_be;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a beat of n bytes must sit on an n-byte boundary; each of its first
  // min(n, left) bytes lands on the lane of its own byte address.
  function automatic bit model_accept(input logic [1:0] ds, input logic [31:0] d);
    int          n;
    int          eff;
    int          ln;
    exp_t        e;
    logic [31:0] ba;
    n = (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
    if ((m_addr % n) != 0) return 1'b1;
    eff     = (n < m_left) ? n : m_left;
    e.addr  = m_addr & 32'hFFFF_FFFC;
    e.wdata = '0;
    e.be    = '0;
    for (int k = 0; k < eff; k++) begin
      ba = m_addr + 32'(k);
      ln = int'(ba[1:0]);
      e.be[ln] = 1'b1;
      e.wdata[8*ln +: 8] = d[8*k +: 8];
    end
    sb.push_back(e);
    m_addr = m_addr + 32'(eff);
    m_left = m_left - eff;
    return 1'b0;
  endfunction

  // Monitor: compares every granted write against the scoreboard and checks that a
  // stalled request is held unchanged.
  always @(negedge clk) begin
    if (!rstn_i) begin
      prev_pend <= 1'b0;
    end else begin
      if (prev_pend)
        chk("req_hold", {27'b0, dp_req_o, dp_addr_o, dp_wdata_o, dp_be_o},
                        {27'b0, 1'b1, prev_addr, prev_wdata, prev_be});
      if (dp_req_o && dp_gnt_i) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got write addr=%08h be=%04b, required no request", dp_addr_o, dp_be_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("write addr=%08h data=%08h be=%04b", dp_addr_o, dp_wdata_o, dp_be_o);
          chk("dp_write", {dp_addr_o, dp_wdata_o, 27'b0, dp_we_o, dp_be_o},
                          {e.addr, e.wdata, 27'b0, 1'b1, e.be});
        end
      end
      prev_pend  <= dp_req_o && !dp_gnt_i;
      prev_addr  <= dp_addr_o;
      prev_wdata <= dp_wdata_o;
      prev_be    <= dp_be_o;
    end
  end

  initial begin
    dp_gnt_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (gnt_mode)
        0:       dp_gnt_i = 1'b0;
        1:       dp_gnt_i = 1'b1;
        default: dp_gnt_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic start_xfer(input logic [31:0] a, input int s);
    cfg_addr_i  = a;
    cfg_size_i  = 20'(s);
    cfg_start_i = 1'b1;
    @(posedge clk);
    #1;
    cfg_start_i = 1'b0;
    m_addr = a;
    m_left = s;
    chk("bytes_left_start", bytes_left_o, s);
  endtask

  task automatic send_beat(input logic [1:0] ds, input logic [31:0] d);
    bit mis;
    bit acc;
    mis = 1'b0;
    acc = 1'b0;
    rx_valid_i    = 1'b1;
    rx_data_i     = d;
    rx_datasize_i = ds;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (rx_ready_o) begin
        mis = model_accept(ds, d);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    rx_valid_i = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL beat_accept: got rx_ready_o low for 100 cycles, required a handshake");
    end else begin
      chk("err_o", err_o, mis);
      chk("bytes_left", bytes_left_o, m_left);
    end
  endtask

  task automatic do_stop();
    cfg_stop_i = 1'b1;
    @(posedge clk);
    #1;
    cfg_stop_i = 1'b0;
    m_left = 0;
    chk("bytes_left_stop", bytes_left_o, 0);
  endtask

  task automatic wait_done(input int exp_cycles);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 1'b0;
    while (cnt < 300 && !seen) begin
      @(negedge clk);
      cnt++;
      if (done_o) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_wait: got no done_o within 300 cycles, required a pulse");
    end else begin
      if (exp_cycles > 0) chk("done_latency", cnt, exp_cycles);
      chk("drained_at_done", sb.size(), 0);
      chk("busy_at_done", busy_o, 0);
      @(negedge clk);
      chk("done_single_pulse", done_o, 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_gnt(input int mode);
    gnt_mode = mode;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int          acc;
    bit          got;
    logic [31:0] a;

    rstn_i        = 1'b0;
    cfg_start_i   = 1'b0;
    cfg_addr_i    = '0;
    cfg_size_i    = '0;
    cfg_stop_i    = 1'b0;
    rx_valid_i    = 1'b0;
    rx_data_i     = '0;
    rx_datasize_i = '0;
    m_addr        = '0;
    m_left        = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {rx_ready_o, dp_req_o, dp_we_o, dp_addr_o, dp_wdata_o, dp_be_o,
                          busy_o, bytes_left_o, done_o, err_o}, '0);
    rstn_i = 1'b1;
    set_gnt(1);

    // byte beats from an odd address, grant always high
    start_xfer(32'h1C00_0001, 3);
    send_beat(2'd0, 32'h0000_00AA);
    send_beat(2'd0, 32'h0000_00BB);
    send_beat(2'd0, 32'h0000_00CC);
    wait_done(2);

    // word beats truncated by the remaining size
    start_xfer(32'h0000_0100, 6);
    send_beat(2'd2, 32'h1122_3344);
    send_beat(2'd2, 32'h5566_7788);
    wait_done(-1);

    // misaligned half is dropped, a following byte still lands
    start_xfer(32'h0000_0101, 4);
    send_beat(2'd1, 32'h0000_BEEF);
    send_beat(2'd0, 32'h0000_005A);
    do_stop();
    wait_done(-1);

    // backpressure: valid held, grant low, FIFO fills
    set_gnt(0);
    start_xfer(32'h0000_0200, 64);
    acc           = 0;
    rx_valid_i    = 1'b1;
    rx_datasize_i = 2'd2;
    rx_data_i     = $urandom;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      got = rx_ready_o;
      if (got) begin
        void'(model_accept(2'd2, rx_data_i));
        acc++;
      end
      @(posedge clk);
      #1;
      if (got) rx_data_i = $urandom;
    end
    @(negedge clk);
    chk("ready_when_full", rx_ready_o, 0);
    chk("bp_accepts", acc, 4);
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
    set_gnt(1);
    while (m_left > 0) send_beat(2'd2, $urandom);
    wait_done(-1);

    // abort after two beats with grant low
    set_gnt(0);
    start_xfer(32'h0000_0400, 32);
    send_beat(2'd2, $urandom);
    send_beat(2'd2, $urandom);
    do_stop();
    rx_valid_i    = 1'b1;
    rx_datasize_i = 2'd2;
    acc           = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rx_ready_o) acc++;
      @(posedge clk);
      #1;
    end
    rx_valid_i = 1'b0;
    chk("abort_accepts", acc, 0);
    chk("busy_after_stop", busy_o, 1);
    gnt_mode = 1;
    wait_done(-1);

    // randomized transfers with random grant, first one wraps the address space
    set_gnt(2);
    for (int t = 0; t < 12; t++) begin
      a = (t == 0) ? 32'hFFFF_FFFA : $urandom;
      start_xfer(a, int'($urandom_range(1, 40)));
      while (m_left > 0) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send_beat(2'($urandom_range(0, 3)), $urandom);
      end
      wait_done(-1);
    end

    // asynchronous reset with a request pending
    set_gnt(0);
    start_xfer(32'h0000_0300, 8);
    send_beat(2'd2, $urandom);
    @(negedge clk);
    chk("req_before_reset", dp_req_o, 1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("reset_mid_outputs", {rx_ready_o, dp_req_o, dp_we_o, dp_addr_o, dp_wdata_o, dp_be_o,
                              busy_o, bytes_left_o, done_o, err_o}, '0);
    sb.delete();
    m_left = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn_i = 1'b1;
    set_gnt(1);
    start_xfer(32'h0000_0500, 4);
    send_beat(2'd2, 32'hCAFE_F00D);
    wait_done(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by 500000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/udma_rx_dp_packer.md
Name: udma_rx_dp_packer

Overview:
- RX datapath stage directly upstream of the uDMA RX data-path-out (L2 write) interface.
- Accepts peripheral RX beats (byte/half/word) for one channel and tracks the destination address and remaining byte count.
- Emits one byte-enabled 32-bit L2 write request per beat through a small request FIFO.
- Signals transfer completion and alignment errors to the channel configuration logic.

Parameters:
- ADDR_W, 32, L2 byte-address width
- TRANS_W, 20, transfer-size counter width (bytes)
- FIFO_DEPTH, 4, request FIFO entries, power of 2, >=2

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_start_i  in  1  single-cycle pulse; loads cfg_addr_i/cfg_size_i and starts the transfer
- cfg_addr_i  in  ADDR_W  start byte address
- cfg_size_i  in  TRANS_W  transfer length in bytes, must be >0
- cfg_stop_i  in  1  abort pulse
- rx_valid_i  in  1  peripheral beat valid
- rx_ready_o  out  1  beat accepted when valid&ready
- rx_data_i  in  32  beat data, LSB-justified
- rx_datasize_i  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- dp_req_o  out  1  write request
- dp_gnt_i  in  1  write grant; the request is consumed on req&gnt
- dp_we_o  out  1  constant 1 while dp_req_o is high
- dp_addr_o  out  ADDR_W  word-aligned address
- dp_wdata_o  out  32  lane-positioned data
- dp_be_o  out  4  byte enables
- busy_o  out  1  transfer active or FIFO non-empty
- bytes_left_o  out  TRANS_W  bytes still to accept
- done_o  out  1  single-cycle pulse when the final write is granted
- err_o  out  1  single-cycle pulse when a misaligned beat is dropped

Behaviour:
- Reset values: all outputs 0. FSM in IDLE, FIFO empty, counters 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on cfg_start_i.
  - RUN -> DRAIN when bytes_left reaches 0.
  - DRAIN -> IDLE on the grant of the final FIFO entry; done_o pulses in that cycle.
- cfg_start_i is ignored outside IDLE. cfg_size_i == 0 also leaves the FSM in IDLE with no done pulse.
- rx_ready_o = (state==RUN) & !fifo_full. It is combinational from registered state only; no dependence on rx_valid_i.
- On accept: n = 1/2/4 bytes; lane = addr[1:0].
  - Misaligned beat (half with addr[0]=1, or word with addr[1:0]!=0): beat dropped, err_o pulses, address and count unchanged.
  - Otherwise: eff = min(n, bytes_left).
  - be = ((1<<eff)-1) << lane.
  - wdata = rx_data_i << 8*lane; unused lanes are 0.
  - Entry {addr & ~3, wdata, be} pushed to the FIFO.
  - addr += eff; bytes_left -= eff.
- Latency: a beat accepted in cycle N gives dp_req_o high in N+1 at the earliest.
- dp_req_o = !fifo_empty. Outputs come from the FIFO head and are held stable until grant (AXI-like rule: the request is never withdrawn without a grant).
- A full FIFO with push and pop in the same cycle is allowed; rx_ready_o still reflects the registered full flag.
- Address wraps modulo 2^ADDR_W with no error.
- cfg_stop_i, any state: FSM -> DRAIN, bytes_left cleared, no further beats accepted. Queued entries still drain, and done_o pulses when the last one is granted (immediately in the next cycle if the FIFO is empty).
- Async reset mid-transfer discards all state; the outstanding request is dropped.

Optional Feature:
- Macro: UDMA_RX_DP_CONT_EN.
- Defined: adds input cfg_continuous_i.
  - When it is high as bytes_left reaches 0, the start address and size are reloaded from shadow registers captured at cfg_start_i, and the FSM stays in RUN.
  - done_o pulses in the cycle the reload happens, without waiting for the drain.
  - cfg_stop_i still terminates the transfer.
- Undefined: the port is absent and the transfer is always single-shot.

Decomposition:
- Package udma_rx_dp_pkg:
  - datasize enum (BYTE/HALF/WORD)
  - FSM state enum
  - request-entry struct {addr, wdata, be}
  - be/lane helper function
- One sub-module, udma_rx_dp_req_fifo: synchronous FIFO of entry structs, FIFO_DEPTH deep, with full/empty flags and concurrent push/pop.

Test Plan:
- Byte beats: start addr=0x1C000001, size=3; bytes 0xAA,0xBB,0xCC, gnt tied high -> writes at 0x1C000000 with be=0010/0100/1000, wdata=0x0000AA00/0x00BB0000/0xCC000000; done_o one cycle after the third req.
- Truncation: addr=0x100, size=6; two word beats 0x11223344, 0x55667788 -> be=1111 @0x100, then be=0011 @0x104; bytes_left_o=0.
- Misalignment: addr=0x101, half beat -> err_o pulse, no dp_req_o, bytes_left_o unchanged; a following byte beat writes be=0010.
- Backpressure: dp_gnt_i=0 for 10 cycles, rx_valid_i held high -> exactly FIFO_DEPTH(4) beats accepted, rx_ready_o low after; dp_addr_o/dp_wdata_o stable; releasing gnt drains in order.
- Abort: cfg_stop_i after 2 of 8 word beats with gnt low -> no further accepts, 2 writes drain, done_o pulses, busy_o falls.
- Reset: rstn_i asserted mid-transfer with a request pending -> all outputs 0 immediately; a new cfg_start_i works normally.
